// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses MAGIC/LEN/payload frames, writes payload bytes and
// releases the CPU reset once a complete image is in memory. Define IMEM_LOADER_CHECKSUM_EN for a trailing CSUM byte.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [7:0]  I_rx_data,
    input  logic        I_rx_valid,
    output logic        O_rx_ready,
    output logic        O_mem_we,
    output logic [31:0] O_mem_addr,
    output logic [7:0]  O_mem_wdata,
    output logic        O_cpu_rst_n,
    output logic        O_done,
    output logic        O_error
);
    localparam int unsigned LEN_W  = 32;
    localparam int unsigned BYTE_W = 8;
    localparam logic [LEN_W-1:0] MEM_LIMIT = LEN_W'(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CSUM = 3'd5
`endif
    } state_t;

    // State entered once the payload is exhausted.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t              state_q;
    state_t              state_nxt;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_nxt;
    logic [1:0]          len_cnt_q;
    logic [1:0]          len_cnt_nxt;
    logic [LEN_W-1:0]    idx_q;
    logic [LEN_W-1:0]    idx_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q;
    logic [BYTE_W-1:0]   csum_nxt;
`endif
    logic                we_nxt;
    logic [LEN_W-1:0]    addr_nxt;
    logic [BYTE_W-1:0]   wdata_nxt;
    logic                done_nxt;
    logic                error_nxt;
    logic                cpu_rst_n_nxt;

    logic                accept;
    logic                is_magic;
    logic [LEN_W-1:0]    len_full;
    logic [LEN_W-1:0]    len_last;

    assign accept   = I_rx_valid && O_rx_ready;
    assign is_magic = (I_rx_data == MAGIC);
    // Length as it stands once the current byte is taken as the MSB.
    assign len_full = {I_rx_data, len_q[23:0]};
    assign len_last = len_q - LEN_W'(1);

    // State and all registered outputs
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            len_cnt_q   <= '0;
            idx_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            O_rx_ready  <= 1'b0;
            O_mem_we    <= 1'b0;
            O_mem_addr  <= '0;
            O_mem_wdata <= '0;
            O_cpu_rst_n <= 1'b0;
            O_done      <= 1'b0;
            O_error     <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            len_q       <= len_nxt;
            len_cnt_q   <= len_cnt_nxt;
            idx_q       <= idx_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_nxt;
`endif
            O_rx_ready  <= 1'b1;
            O_mem_we    <= we_nxt;
            O_mem_addr  <= addr_nxt;
            O_mem_wdata <= wdata_nxt;
            O_cpu_rst_n <= cpu_rst_n_nxt;
            O_done      <= done_nxt;
            O_error     <= error_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (is_magic) state_nxt = ST_LEN;
                end
                ST_LEN: begin
                    if (len_cnt_q == 2'd3) begin
                        if (len_full > MEM_LIMIT)    state_nxt = ST_ERROR;
                        else if (len_full == '0)     state_nxt = ST_TAIL;
                        else                         state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (idx_q == len_last) state_nxt = ST_TAIL;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    state_nxt = (BYTE_W'(csum_q + I_rx_data) == '0) ? ST_DONE : ST_ERROR;
                end
`endif
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        len_nxt     = len_q;
        len_cnt_nxt = len_cnt_q;
        idx_nxt     = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_nxt    = csum_q;
`endif
        we_nxt      = 1'b0;
        addr_nxt    = O_mem_addr;
        wdata_nxt   = O_mem_wdata;
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (is_magic) begin
                        len_nxt     = '0;
                        len_cnt_nxt = '0;
                        idx_nxt     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_nxt    = '0;
`endif
                    end
                end
                ST_LEN: begin
                    len_nxt[{len_cnt_q, 3'b000} +: BYTE_W] = I_rx_data;
                    len_cnt_nxt = len_cnt_q + 2'd1;
                end
                ST_DATA: begin
                    we_nxt    = 1'b1;
                    addr_nxt  = BASE_ADDR + idx_q;
                    wdata_nxt = I_rx_data;
                    idx_nxt   = idx_q + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt  = csum_q + I_rx_data;
`endif
                end
                default: ;
            endcase
        end
        done_nxt      = (state_nxt == ST_DONE);
        cpu_rst_n_nxt = (state_nxt == ST_DONE);
        error_nxt     = (state_nxt == ST_ERROR);
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, write timing, length limit, reset abort and reload.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];

    imem_loader dut (
        .I_clk      (clk),
        .I_rst_n    (rst_n),
        .I_rx_data  (rx_data),
        .I_rx_valid (rx_valid),
        .O_rx_ready (rx_ready),
        .O_mem_we   (mem_we),
        .O_mem_addr (mem_addr),
        .O_mem_wdata(mem_wdata),
        .O_cpu_rst_n(cpu_rst_n),
        .O_done     (done),
        .O_error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log: a strobe seen after edge N is tagged with N.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks += 7;
        if (rx_ready  !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b exp 0", rx_ready); end
        if (mem_we    !== 1'b0)  begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
        if (mem_addr  !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
        if (mem_wdata !== 8'h0)  begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
        if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL reset_cpu_rst_n got %b exp 0", cpu_rst_n); end
        if (done      !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        if (error     !== 1'b0)  begin errors++; $display("FAIL reset_error got %b exp 0", error); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", rx_ready); end
    endtask

    task automatic test_load_ok();
        logic [7:0] pl[4];
        int first_acc;
        pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
        clear_log();
        send(8'h12); send(8'hA5);
        send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        send(pl[0]); first_acc = last_acc;
        send(pl[1]); send(pl[2]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(pl[3]);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL ok_done_early got %b exp 0", done); end
        send(8'hC8);
`else
        send(pl[3]);
`endif
        checks += 3;
        if (done      !== 1'b1) begin errors++; $display("FAIL ok_done got %b exp 1", done); end
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL ok_cpu_rst_n got %b exp 1", cpu_rst_n); end
        if (error     !== 1'b0) begin errors++; $display("FAIL ok_error got %b exp 0", error); end
        idle(3);
        checks++;
        if (wr_addr.size() != 4) begin errors++; $display("FAIL ok_wr_count got %0d exp 4", wr_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr.size()) begin
                checks += 3;
                if (wr_addr[i] !== 32'(i)) begin errors++; $display("FAIL ok_addr[%0d] got %h exp %h", i, wr_addr[i], 32'(i)); end
                if (wr_data[i] !== pl[i])  begin errors++; $display("FAIL ok_data[%0d] got %h exp %h", i, wr_data[i], pl[i]); end
                if (wr_cyc[i] != first_acc + i) begin errors++; $display("FAIL ok_wr_cycle[%0d] got %0d exp %0d", i, wr_cyc[i], first_acc + i); end
            end
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_csum_bad();
        clear_log();
        send(8'hA5);
        checks += 2;
        if (done      !== 1'b0) begin errors++; $display("FAIL restart_done got %b exp 0", done); end
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL restart_cpu_rst_n got %b exp 0", cpu_rst_n); end
        send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        send(8'hC9);
        checks += 3;
        if (error     !== 1'b1) begin errors++; $display("FAIL bad_error got %b exp 1", error); end
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL bad_cpu_rst_n got %b exp 0", cpu_rst_n); end
        if (done      !== 1'b0) begin errors++; $display("FAIL bad_done got %b exp 0", done); end
        idle(2);
        checks++;
        if (wr_addr.size() != 4) begin errors++; $display("FAIL bad_wr_count got %0d exp 4", wr_addr.size()); end
    endtask
`endif

    task automatic test_too_long();
        clear_log();
        send(8'hA5);
        checks += 3;
        if (error     !== 1'b0) begin errors++; $display("FAIL long_error_cleared got %b exp 0", error); end
        if (done      !== 1'b0) begin errors++; $display("FAIL long_done got %b exp 0", done); end
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL long_cpu_rst_n got %b exp 0", cpu_rst_n); end
        send(8'h01); send(8'h04); send(8'h00);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL long_error_early got %b exp 0", error); end
        send(8'h00);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL long_error got %b exp 1", error); end
        send(8'h11); send(8'h22); send(8'h33);
        idle(2);
        checks += 2;
        if (wr_addr.size() != 0) begin errors++; $display("FAIL long_wr_count got %0d exp 0", wr_addr.size()); end
        if (error !== 1'b1) begin errors++; $display("FAIL long_error_sticky got %b exp 1", error); end
    endtask

    task automatic test_zero_len();
        clear_log();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        checks += 3;
        if (done      !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_cpu_rst_n got %b exp 1", cpu_rst_n); end
        if (error     !== 1'b0) begin errors++; $display("FAIL zero_error got %b exp 0", error); end
        idle(2);
        checks++;
        if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_wr_count got %0d exp 0", wr_addr.size()); end
    endtask

    task automatic test_random_valid();
        logic [7:0] pl[16];
        int acc[16];
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            pl[i] = 8'(i * 37 + 5);
            sum   = sum + pl[i];
        end
        clear_log();
        send(8'hA5); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        for (int i = 0; i < 16; i++) begin
            idle(int'($urandom_range(0, 2)));
            send(pl[i]);
            acc[i] = last_acc;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        idle(1);
        send(8'h00 - sum);
`endif
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL rv_done got %b exp 1", done); end
        idle(3);
        checks++;
        if (wr_addr.size() != 16) begin errors++; $display("FAIL rv_wr_count got %0d exp 16", wr_addr.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < wr_addr.size()) begin
                checks += 3;
                if (wr_addr[i] !== 32'(i)) begin errors++; $display("FAIL rv_addr[%0d] got %h exp %h", i, wr_addr[i], 32'(i)); end
                if (wr_data[i] !== pl[i])  begin errors++; $display("FAIL rv_data[%0d] got %h exp %h", i, wr_data[i], pl[i]); end
                if (wr_cyc[i] != acc[i])   begin errors++; $display("FAIL rv_wr_cycle[%0d] got %0d exp %0d", i, wr_cyc[i], acc[i]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        send(8'hA5); send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        send(8'h71); send(8'h72);
        rst_n = 1'b0; rx_valid = 1'b0;
        @(posedge clk); #1;
        checks += 7;
        if (rx_ready  !== 1'b0)  begin errors++; $display("FAIL mid_ready got %b exp 0", rx_ready); end
        if (mem_we    !== 1'b0)  begin errors++; $display("FAIL mid_we got %b exp 0", mem_we); end
        if (mem_addr  !== 32'h0) begin errors++; $display("FAIL mid_addr got %h exp 0", mem_addr); end
        if (mem_wdata !== 8'h0)  begin errors++; $display("FAIL mid_wdata got %h exp 0", mem_wdata); end
        if (cpu_rst_n !== 1'b0)  begin errors++; $display("FAIL mid_cpu_rst_n got %b exp 0", cpu_rst_n); end
        if (done      !== 1'b0)  begin errors++; $display("FAIL mid_done got %b exp 0", done); end
        if (error     !== 1'b0)  begin errors++; $display("FAIL mid_error got %b exp 0", error); end
        rst_n = 1'b1;
        idle(2);
        checks += 2;
        if (wr_addr.size() != 2) begin errors++; $display("FAIL mid_wr_count got %0d exp 2", wr_addr.size()); end
        if (rx_ready !== 1'b1)   begin errors++; $display("FAIL mid_ready_after got %b exp 1", rx_ready); end
        clear_log();
        send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        send(8'h55); send(8'h66);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h45);
`endif
        checks += 2;
        if (done      !== 1'b1) begin errors++; $display("FAIL reload_done got %b exp 1", done); end
        if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL reload_cpu_rst_n got %b exp 1", cpu_rst_n); end
        send(8'hA5);
        checks += 2;
        if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rearm_cpu_rst_n got %b exp 0", cpu_rst_n); end
        if (done      !== 1'b0) begin errors++; $display("FAIL rearm_done got %b exp 0", done); end
        idle(2);
        checks++;
        if (wr_addr.size() != 2) begin errors++; $display("FAIL reload_wr_count got %0d exp 2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks += 4;
            if (wr_addr[0] !== 32'h0) begin errors++; $display("FAIL reload_addr0 got %h exp 0", wr_addr[0]); end
            if (wr_addr[1] !== 32'h1) begin errors++; $display("FAIL reload_addr1 got %h exp 1", wr_addr[1]); end
            if (wr_data[0] !== 8'h55) begin errors++; $display("FAIL reload_data0 got %h exp 55", wr_data[0]); end
            if (wr_data[1] !== 8'h66) begin errors++; $display("FAIL reload_data1 got %h exp 66", wr_data[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_ok();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_csum_bad();
`endif
        test_too_long();
        test_zero_len();
        test_random_valid();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
